// File: rtl/print_int_display.sv
// Captures a signed 32-bit integer on an io_out rising edge, converts it to BCD by
// sequential double-dabble and scans the 8-digit result onto a multiplexed 7-segment display.
module print_int_display #(
    parameter int unsigned SCAN_DIV      = 50000,
    parameter int unsigned BLANK_LEADING = 1
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        io_out,
    input  logic [31:0] a0_data,
    output logic [7:0]  seg_out,
    output logic [7:0]  digit_en,
    output logic        busy,
    output logic        done
);

    localparam logic [1:0] S_IDLE   = 2'd0;
    localparam logic [1:0] S_LOAD   = 2'd1;
    localparam logic [1:0] S_CONV   = 2'd2;
    localparam logic [1:0] S_FORMAT = 2'd3;

    localparam logic [3:0] CODE_DASH  = 4'hA;
    localparam logic [3:0] CODE_BLANK = 4'hF;

    logic [1:0]  state_q, state_d;
    logic        io_q, io_d;
    logic [31:0] bin_q, bin_d;
    logic [39:0] bcd_q, bcd_d;
    logic        sign_q, sign_d;
    logic [4:0]  cnt_q, cnt_d;
    logic [31:0] digits_q, digits_d;
    logic        done_q, done_d;
    logic [15:0] scan_cnt_q, scan_cnt_d;
    logic [2:0]  scan_idx_q, scan_idx_d;
    logic [7:0]  seg_q, seg_d;
    logic [7:0]  den_q, den_d;

    logic        start;
    logic [39:0] bcd_adj;
    logic [31:0] fmt_codes;
    logic        fmt_lead;
    logic        fmt_ovf;
    logic [3:0]  fmt_nib;
    logic        scan_tc;

    function automatic logic [7:0] seg_map(input logic [3:0] code);
        case (code)
            4'd0:    seg_map = 8'hC0;
            4'd1:    seg_map = 8'hF9;
            4'd2:    seg_map = 8'hA4;
            4'd3:    seg_map = 8'hB0;
            4'd4:    seg_map = 8'h99;
            4'd5:    seg_map = 8'h92;
            4'd6:    seg_map = 8'h82;
            4'd7:    seg_map = 8'hF8;
            4'd8:    seg_map = 8'h80;
            4'd9:    seg_map = 8'h90;
            4'hA:    seg_map = 8'hBF;
            default: seg_map = 8'hFF;
        endcase
    endfunction

    assign start = io_out && !io_q && (state_q == S_IDLE);

    always_comb begin
        bcd_adj = '0;
        for (int unsigned i = 0; i < 10; i++) begin
            bcd_adj[4*i +: 4] = (bcd_q[4*i +: 4] >= 4'd5) ? bcd_q[4*i +: 4] + 4'd3
                                                           : bcd_q[4*i +: 4];
        end
    end

    // Leading-zero scan runs from digit 7 down; digit 0 is always shown and a sign dash never ends the run.
    always_comb begin
        fmt_codes = '0;
        fmt_nib   = '0;
        fmt_lead  = (BLANK_LEADING != 0);
        fmt_ovf   = sign_q ? (bcd_q[39:28] != '0) : (bcd_q[39:32] != '0);
        for (int unsigned k = 0; k < 8; k++) begin
            fmt_nib = bcd_q[4*(7-k) +: 4];
            if (sign_q && (k == 0)) begin
                fmt_codes[4*(7-k) +: 4] = CODE_DASH;
            end else if (fmt_lead && (fmt_nib == 4'd0) && (k != 7)) begin
                fmt_codes[4*(7-k) +: 4] = CODE_BLANK;
            end else begin
                fmt_codes[4*(7-k) +: 4] = fmt_nib;
                fmt_lead = 1'b0;
            end
        end
        if (fmt_ovf) begin
            fmt_codes = {8{CODE_DASH}};
        end
    end

    always_comb begin
        state_d  = state_q;
        io_d     = io_out;
        bin_d    = bin_q;
        bcd_d    = bcd_q;
        sign_d   = sign_q;
        cnt_d    = cnt_q;
        digits_d = digits_q;
        done_d   = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (start) begin
                    bin_d   = a0_data;
                    state_d = S_LOAD;
                end
            end
            S_LOAD: begin
                sign_d  = bin_q[31];
                bin_d   = bin_q[31] ? (~bin_q + 32'd1) : bin_q;
                bcd_d   = '0;
                cnt_d   = '0;
                state_d = S_CONV;
            end
            S_CONV: begin
                {bcd_d, bin_d} = {bcd_adj[38:0], bin_q, 1'b0};
                cnt_d = cnt_q + 5'd1;
                if (cnt_q == 5'd31) begin
                    state_d = S_FORMAT;
                end
            end
            default: begin
                digits_d = fmt_codes;
                done_d   = 1'b1;
                state_d  = S_IDLE;
            end
        endcase
    end

    always_comb begin
        scan_tc    = (scan_cnt_q == 16'(SCAN_DIV - 1));
        scan_cnt_d = scan_tc ? '0 : scan_cnt_q + 16'd1;
        scan_idx_d = scan_tc ? scan_idx_q + 3'd1 : scan_idx_q;
        den_d      = ~(8'd1 << scan_idx_q);
        seg_d      = seg_map(digits_q[4*scan_idx_q +: 4]);
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q    <= S_IDLE;
            io_q       <= 1'b1;
            bin_q      <= '0;
            bcd_q      <= '0;
            sign_q     <= 1'b0;
            cnt_q      <= '0;
            digits_q   <= '1;
            done_q     <= 1'b0;
            scan_cnt_q <= '0;
            scan_idx_q <= '0;
            seg_q      <= 8'hFF;
            den_q      <= 8'hFE;
        end else begin
            state_q    <= state_d;
            io_q       <= io_d;
            bin_q      <= bin_d;
            bcd_q      <= bcd_d;
            sign_q     <= sign_d;
            cnt_q      <= cnt_d;
            digits_q   <= digits_d;
            done_q     <= done_d;
            scan_cnt_q <= scan_cnt_d;
            scan_idx_q <= scan_idx_d;
            seg_q      <= seg_d;
            den_q      <= den_d;
        end
    end

    assign seg_out  = seg_q;
    assign digit_en = den_q;
    assign busy     = (state_q != S_IDLE);
    assign done     = done_q;

endmodule
